// File: rtl/maxpool_sub_pkg.sv
// maxpool_sub_pkg
// Shared defines for the convolution / pooling datapath.
//   DATAW  : signed fixed-point data word, 4 integer + 16 fraction bits
//   ADDRW  : convolution-result address {row[5:0], col[5:0]} (64x64 image)
//   POOLW  : pooled address {row[4:0], col[4:0]} (32x32 map)
// Also provides the window-slot constants and two address helpers used by
// the 2x2 max-pool block.
package maxpool_sub_pkg;

  localparam int DATAW = 20;
  localparam int ADDRW = 12;
  localparam int POOLW = 10;

  typedef logic signed [DATAW-1:0] dataT;
  typedef logic [ADDRW-1:0]        convAddrT;
  typedef logic [POOLW-1:0]        poolAddrT;

  // Position of a result inside its 2x2 window: {row odd, col odd}.
  localparam logic [1:0] SLOT0 = 2'd0;  // (even, even)
  localparam logic [1:0] SLOT1 = 2'd1;  // (even, odd)
  localparam logic [1:0] SLOT2 = 2'd2;  // (odd,  even)
  localparam logic [1:0] SLOT3 = 2'd3;  // (odd,  odd)

  // Pooled outputs per frame is 32*32; the counter wraps after this value.
  localparam logic [POOLW-1:0] FRAME_LAST = 10'd1023;

  // Slot of a convolution address: {row[0], col[0]}.
  function automatic logic [1:0] slotOf(input convAddrT addr);
    return {addr[6], addr[0]};
  endfunction

  // Window base (pooled coordinate) of a convolution address.
  function automatic poolAddrT baseOf(input convAddrT addr);
    return {addr[11:7], addr[5:1]};
  endfunction

endpackage

// File: rtl/maxpool_sub_max2.sv
// max2
// Combinational signed maximum of two DATAW operands.
// Ports:
//   a   : candidate (new) value
//   b   : stored value
//   max : a when a is strictly greater than b, otherwise b, so a tie keeps
//         the stored operand.
module max2
  import maxpool_sub_pkg::*;
(
  input  logic signed [DATAW-1:0] a,
  input  logic signed [DATAW-1:0] b,
  output logic signed [DATAW-1:0] max
);

  assign max = (a > b) ? a : b;

endmodule

// File: rtl/maxpool_sub.sv
// maxpool_sub
// 2x2 max-pooling of two kernel result streams coming out of the
// convolution block. Four consecutive strobes in producer order
// (r,c),(r,c+1),(r+1,c),(r+1,c+1) form one window; the maximum of each
// kernel over the window is emitted with the pooled coordinate.
//
// Ports:
//   clk, reset      : clock (rising edge), synchronous active-low reset
//   en              : pooling phase enable; low clears the window state
//   convValid       : one-cycle strobe qualifying convAddr/convK0/convK1
//   convAddr        : {row[5:0], col[5:0]} of the incoming result
//   convK0, convK1  : kernel-0 / kernel-1 results (signed, post-ReLU)
//   poolValid       : one-cycle strobe qualifying poolAddr/poolK0/poolK1
//   poolAddr        : {row[4:0], col[4:0]} of the pooled window
//   poolK0, poolK1  : window maxima, held until the next poolValid
//   frameDone       : asserted with the 1024th poolValid of a frame
//   seqErr          : sticky, set by any out-of-order input since reset
//
// Handshake: there is no back-pressure. An input is consumed on every
// rising edge where en and convValid are both high (one per cycle is
// sustained); an output is presented for exactly the cycle poolValid is
// high, the cycle after the edge that consumed the slot-3 input, and the
// consumer must take it then.
module maxpool_sub
  import maxpool_sub_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             convValid,
  input  logic [ADDRW-1:0] convAddr,
  input  logic [DATAW-1:0] convK0,
  input  logic [DATAW-1:0] convK1,
  output logic             poolValid,
  output logic [POOLW-1:0] poolAddr,
  output logic [DATAW-1:0] poolK0,
  output logic [DATAW-1:0] poolK1,
  output logic             frameDone,
  output logic             seqErr
);

  // Window state
  logic [1:0]       slotCnt;   // expected slot of the next input
  logic [POOLW-1:0] base;      // pooled coordinate latched at slot 0
  logic [DATAW-1:0] maxK0;
  logic [DATAW-1:0] maxK1;
  logic [POOLW-1:0] outCnt;    // pooled outputs issued in this frame

  // Decode of the incoming strobe
  logic [1:0]       inSlot;
  logic [POOLW-1:0] inBase;
  logic             strobe;
  logic             inOrder;
  logic             accept;
  logic             mismatch;
  logic             restart;
  logic             complete;
  logic [DATAW-1:0] newMaxK0;
  logic [DATAW-1:0] newMaxK1;

  assign inSlot = slotOf(convAddr);
  assign inBase = baseOf(convAddr);
  assign strobe = en & convValid;

  // Slot 0 opens a window, so only its slot is checked; later slots must
  // also belong to the window opened by slot 0.
  assign inOrder  = (inSlot == slotCnt) && ((slotCnt == SLOT0) || (inBase == base));
  assign accept   = strobe & inOrder;
  assign mismatch = strobe & ~inOrder;
  // An out-of-order slot-0 input is itself a valid window start.
  assign restart  = mismatch & (inSlot == SLOT0);
  assign complete = accept & (slotCnt == SLOT3);

  // The incoming value is operand a, so a tie keeps the stored maximum.
  max2 u_max2K0 (
    .a   (convK0),
    .b   (maxK0),
    .max (newMaxK0)
  );

  max2 u_max2K1 (
    .a   (convK1),
    .b   (maxK1),
    .max (newMaxK1)
  );

  // Slot counter and running maxima
  always_ff @(posedge clk) begin
    if (!reset) begin
      slotCnt <= SLOT0;
      base    <= '0;
      maxK0   <= '0;
      maxK1   <= '0;
    end else if (!en) begin
      slotCnt <= SLOT0;
    end else if (accept) begin
      slotCnt <= slotCnt + 2'd1;
      if (slotCnt == SLOT0) begin
        base  <= inBase;
        maxK0 <= convK0;
        maxK1 <= convK1;
      end else begin
        maxK0 <= newMaxK0;
        maxK1 <= newMaxK1;
      end
    end else if (restart) begin
      slotCnt <= SLOT1;
      base    <= inBase;
      maxK0   <= convK0;
      maxK1   <= convK1;
    end else if (mismatch) begin
      slotCnt <= SLOT0;
    end
  end

  // Output registers and frame counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      poolValid <= 1'b0;
      frameDone <= 1'b0;
      poolAddr  <= '0;
      poolK0    <= '0;
      poolK1    <= '0;
      outCnt    <= '0;
    end else begin
      poolValid <= 1'b0;
      frameDone <= 1'b0;
      if (complete) begin
        poolValid <= 1'b1;
        frameDone <= (outCnt == FRAME_LAST);
        poolAddr  <= base;
        poolK0    <= newMaxK0;
        poolK1    <= newMaxK1;
        outCnt    <= outCnt + 10'd1;
      end
    end
  end

  // Sticky sequence error
  always_ff @(posedge clk) begin
    if (!reset) begin
      seqErr <= 1'b0;
    end else if (mismatch) begin
      seqErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxpool_sub.sv
// tb_maxpool_sub
// Directed bench for maxpool_sub. Stimulus tasks push the expected pooled
// result into exp_q when they issue the completing strobe; a monitor on the
// falling edge pops and compares whenever poolValid is high.
module tb_maxpool_sub;
  import maxpool_sub_pkg::*;

  localparam int EW = 1 + POOLW + 2 * DATAW;  // {frameDone, addr, k0, k1}

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             convValid;
  logic [ADDRW-1:0] convAddr;
  logic [DATAW-1:0] convK0;
  logic [DATAW-1:0] convK1;
  logic             poolValid;
  logic [POOLW-1:0] poolAddr;
  logic [DATAW-1:0] poolK0;
  logic [DATAW-1:0] poolK1;
  logic             frameDone;
  logic             seqErr;

  always #5 clk = ~clk;

  maxpool_sub dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .convValid (convValid),
    .convAddr  (convAddr),
    .convK0    (convK0),
    .convK1    (convK1),
    .poolValid (poolValid),
    .poolAddr  (poolAddr),
    .poolK0    (poolK0),
    .poolK1    (poolK1),
    .frameDone (frameDone),
    .seqErr    (seqErr)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            pool_cnt = 0;  // expected pooled outputs since reset

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] smax(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  task automatic push_exp(input logic [POOLW-1:0] addr, input logic [DATAW-1:0] k0,
                          input logic [DATAW-1:0] k1);
    logic fd;
    fd = (pool_cnt == 1023);
    pool_cnt = (pool_cnt + 1) % 1024;
    exp_q.push_back({fd, addr, k0, k1});
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic strobe(input int row, input int col, input logic [DATAW-1:0] k0,
                        input logic [DATAW-1:0] k1);
    logic [5:0] r6;
    logic [5:0] c6;
    r6 = row[5:0];
    c6 = col[5:0];
    convValid = 1'b1;
    convAddr  = {r6, c6};
    convK0    = k0;
    convK1    = k1;
    @(posedge clk);
    #1;
    convValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full window at even (r,c) with hand-computed expected maxima.
  task automatic window(input int r, input int c,
                        input logic [DATAW-1:0] a0, input logic [DATAW-1:0] b0,
                        input logic [DATAW-1:0] c0, input logic [DATAW-1:0] d0,
                        input logic [DATAW-1:0] a1, input logic [DATAW-1:0] b1,
                        input logic [DATAW-1:0] c1, input logic [DATAW-1:0] d1,
                        input logic [POOLW-1:0] expAddr,
                        input logic [DATAW-1:0] expK0, input logic [DATAW-1:0] expK1);
    strobe(r,     c,     a0, a1);
    strobe(r,     c + 1, b0, b1);
    strobe(r + 1, c,     c0, c1);
    push_exp(expAddr, expK0, expK1);
    strobe(r + 1, c + 1, d0, d1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    convValid = 1'b0;
    idle(2);
    reset = 1'b1;
    pool_cnt = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      if (frameDone && !poolValid) begin
        n_tests++;
        n_fail++;
        $display("FAIL frameDone_alone: frameDone=1 with poolValid=0");
      end
      if (poolValid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pool: poolAddr=0x%0h with no expected output", poolAddr);
        end else begin
          e = exp_q.pop_front();
          check("poolAddr",  64'(poolAddr),  64'(e[EW-2 -: POOLW]));
          check("poolK0",    64'(poolK0),    64'(e[2*DATAW-1 -: DATAW]));
          check("poolK1",    64'(poolK1),    64'(e[DATAW-1:0]));
          check("frameDone", 64'(frameDone), 64'(e[EW-1]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    en        = 1'b0;
    convValid = 1'b0;
    convAddr  = '0;
    convK0    = '0;
    convK1    = '0;
    idle(3);

    check("rst_poolValid", 64'(poolValid), 64'd0);
    check("rst_poolAddr",  64'(poolAddr),  64'd0);
    check("rst_poolK0",    64'(poolK0),    64'd0);
    check("rst_poolK1",    64'(poolK1),    64'd0);
    check("rst_frameDone", 64'(frameDone), 64'd0);
    check("rst_seqErr",    64'(seqErr),    64'd0);

    reset = 1'b1;
    en    = 1'b1;
    idle(1);

    // Basic window at (0,0)
    window(0, 0, 20'h01000, 20'h03000, 20'h02000, 20'h00800,
                 20'h00000, 20'h00010, 20'h00020, 20'h00005,
                 10'h000, 20'h03000, 20'h00020);
    // Bottom rows, max only in slot 3 for K1, tie on K0
    window(62, 2, 20'h00000, 20'h00100, 20'h00100, 20'h00080,
                  20'h00000, 20'h00000, 20'h00000, 20'h05E68,
                  10'h3E1, 20'h00100, 20'h05E68);
    // Signed comparisons
    window(10, 20, 20'h80000, 20'hFFFFF, 20'h7FFFF, 20'h00001,
                   20'hFFFFF, 20'h80000, 20'hC0000, 20'hFFFFE,
                   10'h0AA, 20'h7FFFF, 20'hFFFFF);
    idle(2);
    drain("basic_drain");
    check("basic_seqErr", 64'(seqErr), 64'd0);

    // en dropped mid-window, strobe while disabled, then a fresh window
    strobe(4, 6, 20'h7FFFF, 20'h7FFFF);
    strobe(4, 7, 20'h7FFFF, 20'h7FFFF);
    strobe(5, 6, 20'h7FFFF, 20'h7FFFF);
    en = 1'b0;
    idle(1);
    strobe(5, 7, 20'h7FFFF, 20'h7FFFF);
    idle(1);
    en = 1'b1;
    window(8, 8, 20'h00111, 20'h00222, 20'h00333, 20'h00044,
                 20'h00009, 20'h00008, 20'h00007, 20'h00006,
                 10'h084, 20'h00333, 20'h00009);
    idle(2);
    drain("en_drain");
    check("en_seqErr", 64'(seqErr), 64'd0);

    // Slot 2 skipped: error, no output; then the correct window
    strobe(2, 4, 20'h40000, 20'h40000);
    strobe(2, 5, 20'h40000, 20'h40000);
    strobe(3, 5, 20'h40000, 20'h40000);
    idle(3);
    check("skip_seqErr", 64'(seqErr), 64'd1);
    window(2, 4, 20'h00001, 20'h00002, 20'h00003, 20'h00004,
                 20'h00040, 20'h00030, 20'h00020, 20'h00010,
                 10'h022, 20'h00004, 20'h00040);
    idle(2);
    drain("skip_drain");
    check("skip_seqErr_sticky", 64'(seqErr), 64'd1);

    // Reset after slot 1
    strobe(0, 2, 20'h7FFFF, 20'h7FFFF);
    strobe(0, 3, 20'h7FFFF, 20'h7FFFF);
    reset = 1'b0;
    idle(1);
    check("midrst_poolValid", 64'(poolValid), 64'd0);
    check("midrst_poolAddr",  64'(poolAddr),  64'd0);
    check("midrst_poolK0",    64'(poolK0),    64'd0);
    check("midrst_poolK1",    64'(poolK1),    64'd0);
    check("midrst_frameDone", 64'(frameDone), 64'd0);
    check("midrst_seqErr",    64'(seqErr),    64'd0);
    reset = 1'b1;
    pool_cnt = 0;
    window(0, 2, 20'h00500, 20'h00400, 20'h00300, 20'h00200,
                 20'h00002, 20'h00003, 20'h00001, 20'h00000,
                 10'h001, 20'h00500, 20'h00003);
    idle(2);
    drain("midrst_drain");
    check("midrst_seqErr_after", 64'(seqErr), 64'd0);

    // Full frame, back-to-back, producer column-major window order
    apply_reset();
    for (int wc = 0; wc < 32; wc++) begin
      for (int wr = 0; wr < 32; wr++) begin
        logic [DATAW-1:0] k0[4];
        logic [DATAW-1:0] k1[4];
        logic [DATAW-1:0] m0;
        logic [DATAW-1:0] m1;
        logic [4:0] r5;
        logic [4:0] c5;
        for (int s = 0; s < 4; s++) begin
          k0[s] = 20'($urandom_range(0, 20'hFFFFF));
          k1[s] = 20'($urandom_range(0, 20'hFFFFF));
        end
        m0 = smax(smax(k0[0], k0[1]), smax(k0[2], k0[3]));
        m1 = smax(smax(k1[0], k1[1]), smax(k1[2], k1[3]));
        r5 = wr[4:0];
        c5 = wc[4:0];
        strobe(2 * wr,     2 * wc,     k0[0], k1[0]);
        strobe(2 * wr,     2 * wc + 1, k0[1], k1[1]);
        strobe(2 * wr + 1, 2 * wc,     k0[2], k1[2]);
        push_exp({r5, c5}, m0, m1);
        strobe(2 * wr + 1, 2 * wc + 1, k0[3], k1[3]);
      end
    end
    idle(2);
    drain("frame_drain");
    check("frame_seqErr", 64'(seqErr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit 2000000");
    $fatal(1);
  end

endmodule
